// File: rtl/banked_dp_pkg.sv
// Shared constants and width helpers for the banked dual-port scheduler.
package banked_dp_pkg;
    localparam int RD_PIPE_DEPTH  = 2;
    localparam int CONFLICT_CNT_W = 16;

    function automatic int bank_sel_w(input int num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int bank_addr_w(input int num_banks, input int mem_depth);
        return $clog2(num_banks * mem_depth) - $clog2(num_banks);
    endfunction
endpackage

// File: rtl/bank_port_stage.sv
// One port's bank decode, registered bank request and two-stage read-return pipeline.
module bank_port_stage
    import banked_dp_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_SEL_W = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_accept,
    input  logic                            i_we,
    input  logic [ADDR_WIDTH-1:0]           i_addr,
    input  logic [DATA_WIDTH-1:0]           i_data,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_bank_rdata,
    output logic [BANK_SEL_W-1:0]           o_bank_sel,
    output logic [NUM_BANKS-1:0]            o_bank_en,
    output logic                            o_bank_we,
    output logic [ADDR_WIDTH-BANK_SEL_W-1:0] o_bank_addr,
    output logic [DATA_WIDTH-1:0]           o_bank_data,
    output logic [DATA_WIDTH-1:0]           o_rdata,
    output logic                            o_rvalid
);
    localparam int WORD_W = ADDR_WIDTH - BANK_SEL_W;

    logic [RD_PIPE_DEPTH-1:0]                 rd_vld;
    logic [RD_PIPE_DEPTH-1:0][BANK_SEL_W-1:0] rd_bank;
    logic [BANK_SEL_W-1:0]                    ret_bank;
    logic [DATA_WIDTH-1:0]                    rdata_mux;

    assign o_bank_sel = i_addr[ADDR_WIDTH-1 -: BANK_SEL_W];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bank_en   <= '0;
            o_bank_we   <= 1'b0;
            o_bank_addr <= '0;
            o_bank_data <= '0;
            rd_vld      <= '0;
            rd_bank     <= '0;
        end else begin
            o_bank_en <= i_accept ? ({{(NUM_BANKS-1){1'b0}}, 1'b1} << o_bank_sel) : '0;
            // Request fields only move on an accepted cycle; the strobe alone marks validity.
            if (i_accept) begin
                o_bank_we   <= i_we;
                o_bank_addr <= i_addr[WORD_W-1:0];
                o_bank_data <= i_data;
            end
            rd_vld  <= {rd_vld[RD_PIPE_DEPTH-2:0], i_accept & ~i_we};
            rd_bank <= {rd_bank[RD_PIPE_DEPTH-2:0], o_bank_sel};
        end
    end

    assign ret_bank = rd_bank[RD_PIPE_DEPTH-1];
    assign o_rvalid = rd_vld[RD_PIPE_DEPTH-1];

    always_comb begin
        rdata_mux = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (ret_bank == BANK_SEL_W'(k)) begin
                rdata_mux = i_bank_rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_rdata = o_rvalid ? rdata_mux : '0;
endmodule

// File: rtl/banked_dp_scheduler.sv
// Routes two request ports onto NUM_BANKS single-port banks with round-robin collision arbitration.
// Optional BANK_CONFLICT_STATS_EN adds a saturating conflict counter and per-port stall flags.
module banked_dp_scheduler
    import banked_dp_pkg::*;
#(
    parameter int MEM_DEPTH  = 64,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_SEL_W = bank_sel_w(NUM_BANKS),
    parameter int ADDR_WIDTH = BANK_SEL_W + bank_addr_w(NUM_BANKS, MEM_DEPTH),
    parameter int DATA_WIDTH = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_ena,
    input  logic                             i_enb,
    input  logic                             i_wea,
    input  logic                             i_web,
    input  logic [ADDR_WIDTH-1:0]            i_addra,
    input  logic [ADDR_WIDTH-1:0]            i_addrb,
    input  logic [DATA_WIDTH-1:0]            i_data_a,
    input  logic [DATA_WIDTH-1:0]            i_data_b,
    output logic                             o_rdy_a,
    output logic                             o_rdy_b,
    output logic [NUM_BANKS-1:0]             o_bank_en_a,
    output logic [NUM_BANKS-1:0]             o_bank_en_b,
    output logic                             o_bank_we_a,
    output logic                             o_bank_we_b,
    output logic [ADDR_WIDTH-BANK_SEL_W-1:0] o_bank_addr_a,
    output logic [ADDR_WIDTH-BANK_SEL_W-1:0] o_bank_addr_b,
    output logic [DATA_WIDTH-1:0]            o_bank_data_a,
    output logic [DATA_WIDTH-1:0]            o_bank_data_b,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]  i_bank_rdata_a,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]  i_bank_rdata_b,
    output logic [DATA_WIDTH-1:0]            o_rdata_a,
    output logic [DATA_WIDTH-1:0]            o_rdata_b,
    output logic                             o_rvalid_a,
    output logic                             o_rvalid_b
`ifdef BANK_CONFLICT_STATS_EN
    ,
    output logic [CONFLICT_CNT_W-1:0]        o_conflict_cnt,
    output logic                             o_stall_a,
    output logic                             o_stall_b
`endif
);
    logic [BANK_SEL_W-1:0] sel_a, sel_b;
    logic                  conflict, prio, accept_a, accept_b;

    assign conflict = i_ena & i_enb & (sel_a == sel_b);
    assign o_rdy_a  = ~conflict | ~prio;
    assign o_rdy_b  = ~conflict | prio;
    assign accept_a = i_ena & o_rdy_a;
    assign accept_b = i_enb & o_rdy_b;

    // Each collision hands priority to the loser, so a standing collision alternates winners.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prio <= 1'b0;
        end else if (conflict) begin
            prio <= ~prio;
        end
    end

    bank_port_stage #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_SEL_W(BANK_SEL_W),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_port_a (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_accept    (accept_a),
        .i_we        (i_wea),
        .i_addr      (i_addra),
        .i_data      (i_data_a),
        .i_bank_rdata(i_bank_rdata_a),
        .o_bank_sel  (sel_a),
        .o_bank_en   (o_bank_en_a),
        .o_bank_we   (o_bank_we_a),
        .o_bank_addr (o_bank_addr_a),
        .o_bank_data (o_bank_data_a),
        .o_rdata     (o_rdata_a),
        .o_rvalid    (o_rvalid_a)
    );

    bank_port_stage #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_SEL_W(BANK_SEL_W),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_port_b (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_accept    (accept_b),
        .i_we        (i_web),
        .i_addr      (i_addrb),
        .i_data      (i_data_b),
        .i_bank_rdata(i_bank_rdata_b),
        .o_bank_sel  (sel_b),
        .o_bank_en   (o_bank_en_b),
        .o_bank_we   (o_bank_we_b),
        .o_bank_addr (o_bank_addr_b),
        .o_bank_data (o_bank_data_b),
        .o_rdata     (o_rdata_b),
        .o_rvalid    (o_rvalid_b)
    );

`ifdef BANK_CONFLICT_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_conflict_cnt <= '0;
        end else if (conflict && (o_conflict_cnt != '1)) begin
            o_conflict_cnt <= o_conflict_cnt + CONFLICT_CNT_W'(1);
        end
    end

    assign o_stall_a = i_ena & ~o_rdy_a;
    assign o_stall_b = i_enb & ~o_rdy_b;
`endif
endmodule

// File: tb/tb_banked_dp_scheduler.sv
// Directed scenarios plus a randomized run against a cycle-indexed transaction model.
module tb_banked_dp_scheduler;
    localparam int DW   = 8;
    localparam int NB   = 4;
    localparam int AW   = 8;
    localparam int WW   = 6;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ena, enb, wea, web, rdy_a, rdy_b;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] data_a, data_b, bank_data_a, bank_data_b, rdata_a, rdata_b;
    logic [NB-1:0] bank_en_a, bank_en_b;
    logic bank_we_a, bank_we_b, rvalid_a, rvalid_b;
    logic [WW-1:0] bank_addr_a, bank_addr_b;
    logic [NB*DW-1:0] bank_rdata_a, bank_rdata_b;
`ifdef BANK_CONFLICT_STATS_EN
    logic [15:0] conflict_cnt;
    logic stall_a, stall_b;
`endif

    logic p8_ena, p8_enb, p8_wea, p8_web, p8_rdy_a, p8_rdy_b;
    logic [7:0] p8_addra, p8_addrb;
    logic [DW-1:0] p8_data_a, p8_data_b, p8_bank_data_a, p8_bank_data_b, p8_rdata_a, p8_rdata_b;
    logic [7:0] p8_bank_en_a, p8_bank_en_b;
    logic p8_bank_we_a, p8_bank_we_b, p8_rvalid_a, p8_rvalid_b;
    logic [4:0] p8_bank_addr_a, p8_bank_addr_b;
    logic [8*DW-1:0] p8_bank_rdata_a, p8_bank_rdata_b;
`ifdef BANK_CONFLICT_STATS_EN
    logic [15:0] p8_conflict_cnt;
    logic p8_stall_a, p8_stall_b;
`endif

    int n_pass = 0;
    int n_total = 0;

    banked_dp_scheduler u_dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
        .i_addra(addra), .i_addrb(addrb), .i_data_a(data_a), .i_data_b(data_b),
        .o_rdy_a(rdy_a), .o_rdy_b(rdy_b), .o_bank_en_a(bank_en_a), .o_bank_en_b(bank_en_b),
        .o_bank_we_a(bank_we_a), .o_bank_we_b(bank_we_b),
        .o_bank_addr_a(bank_addr_a), .o_bank_addr_b(bank_addr_b),
        .o_bank_data_a(bank_data_a), .o_bank_data_b(bank_data_b),
        .i_bank_rdata_a(bank_rdata_a), .i_bank_rdata_b(bank_rdata_b),
        .o_rdata_a(rdata_a), .o_rdata_b(rdata_b), .o_rvalid_a(rvalid_a), .o_rvalid_b(rvalid_b)
`ifdef BANK_CONFLICT_STATS_EN
        , .o_conflict_cnt(conflict_cnt), .o_stall_a(stall_a), .o_stall_b(stall_b)
`endif
    );

    banked_dp_scheduler #(.MEM_DEPTH(32), .NUM_BANKS(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_ena(p8_ena), .i_enb(p8_enb), .i_wea(p8_wea), .i_web(p8_web),
        .i_addra(p8_addra), .i_addrb(p8_addrb), .i_data_a(p8_data_a), .i_data_b(p8_data_b),
        .o_rdy_a(p8_rdy_a), .o_rdy_b(p8_rdy_b), .o_bank_en_a(p8_bank_en_a), .o_bank_en_b(p8_bank_en_b),
        .o_bank_we_a(p8_bank_we_a), .o_bank_we_b(p8_bank_we_b),
        .o_bank_addr_a(p8_bank_addr_a), .o_bank_addr_b(p8_bank_addr_b),
        .o_bank_data_a(p8_bank_data_a), .o_bank_data_b(p8_bank_data_b),
        .i_bank_rdata_a(p8_bank_rdata_a), .i_bank_rdata_b(p8_bank_rdata_b),
        .o_rdata_a(p8_rdata_a), .o_rdata_b(p8_rdata_b), .o_rvalid_a(p8_rvalid_a), .o_rvalid_b(p8_rvalid_b)
`ifdef BANK_CONFLICT_STATS_EN
        , .o_conflict_cnt(p8_conflict_cnt), .o_stall_a(p8_stall_a), .o_stall_b(p8_stall_b)
`endif
    );

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; enb = 1'b1; wea = 1'b0; web = 1'b0;
        addra = 8'h10; addrb = 8'h20;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({bank_en_a, bank_en_b, bank_we_a, bank_we_b} !== 10'd0)
            $display("FAIL reset_strobes: got %b expected 0", {bank_en_a, bank_en_b, bank_we_a, bank_we_b});
        else n_pass++;
        n_total++;
        if ({bank_addr_a, bank_addr_b, bank_data_a, bank_data_b} !== 28'd0)
            $display("FAIL reset_addr_data: got %h expected 0", {bank_addr_a, bank_addr_b, bank_data_a, bank_data_b});
        else n_pass++;
        n_total++;
        if ({rvalid_a, rvalid_b, rdata_a, rdata_b} !== 18'd0)
            $display("FAIL reset_rvalid: got %h expected 0", {rvalid_a, rvalid_b, rdata_a, rdata_b});
        else n_pass++;
        n_total++;
        if ({rdy_a, rdy_b} !== 2'b10)
            $display("FAIL reset_prio: rdy got %b expected 10", {rdy_a, rdy_b});
        else n_pass++;
`ifdef BANK_CONFLICT_STATS_EN
        n_total++;
        if (conflict_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", conflict_cnt);
        else n_pass++;
`endif
        @(negedge clk);
        rst = 1'b0; ena = 1'b0; enb = 1'b0;
    endtask

    task automatic test_disjoint();
        @(negedge clk);
        ena = 1'b1; wea = 1'b1; addra = 8'h05; data_a = 8'h0A;
        enb = 1'b1; web = 1'b1; addrb = 8'hC5; data_b = 8'h0B;
        #1;
        n_total++;
        if ({rdy_a, rdy_b} !== 2'b11) $display("FAIL disjoint_rdy: got %b expected 11", {rdy_a, rdy_b});
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({bank_en_a, bank_en_b} !== 8'b0001_1000)
            $display("FAIL disjoint_strobe: got %b expected 00011000", {bank_en_a, bank_en_b});
        else n_pass++;
        n_total++;
        if ({bank_addr_a, bank_addr_b, bank_data_a, bank_data_b, bank_we_a, bank_we_b} !== {6'h05, 6'h05, 8'h0A, 8'h0B, 2'b11})
            $display("FAIL disjoint_fields: got %h", {bank_addr_a, bank_addr_b, bank_data_a, bank_data_b, bank_we_a, bank_we_b});
        else n_pass++;
        @(negedge clk);
        ena = 1'b0; enb = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({bank_en_a, bank_en_b, bank_addr_a, bank_data_a, bank_we_a} !== {8'd0, 6'h05, 8'h0A, 1'b1})
            $display("FAIL idle_hold: got %h", {bank_en_a, bank_en_b, bank_addr_a, bank_data_a, bank_we_a});
        else n_pass++;
    endtask

    task automatic test_conflict();
        logic [1:0] exp_rdy;
        logic [7:0] exp_en;
        @(negedge clk);
        ena = 1'b1; enb = 1'b1; wea = 1'b0; web = 1'b0; addra = 8'h81; addrb = 8'h92;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            exp_rdy = (i == 1) ? 2'b01 : 2'b10;
            exp_en  = (i == 1) ? 8'b0000_0100 : 8'b0100_0000;
            #1;
            n_total++;
            if ({rdy_a, rdy_b} !== exp_rdy)
                $display("FAIL conflict_rdy[%0d]: got %b expected %b", i, {rdy_a, rdy_b}, exp_rdy);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if ({bank_en_a, bank_en_b} !== exp_en)
                $display("FAIL conflict_strobe[%0d]: got %b expected %b", i, {bank_en_a, bank_en_b}, exp_en);
            else n_pass++;
        end
        n_total++;
        if ({bank_addr_a, bank_addr_b} !== {6'h01, 6'h12})
            $display("FAIL conflict_addr: got %h expected 0112", {bank_addr_a, bank_addr_b});
        else n_pass++;
`ifdef BANK_CONFLICT_STATS_EN
        n_total++;
        if (conflict_cnt !== 16'd3) $display("FAIL conflict_cnt: got %0d expected 3", conflict_cnt);
        else n_pass++;
`endif
        @(negedge clk);
        ena = 1'b0; enb = 1'b0;
    endtask

    task automatic test_read_return();
        bank_rdata_a = {8'h33, 8'h22, 8'h5A, 8'h11};
        repeat (2) @(posedge clk);
        @(negedge clk);
        ena = 1'b1; wea = 1'b0; addra = 8'h41;
        @(posedge clk); #1;
        n_total++;
        if ({rvalid_a, bank_en_a, bank_addr_a, bank_we_a} !== {1'b0, 4'b0010, 6'h01, 1'b0})
            $display("FAIL read_issue: got %h", {rvalid_a, bank_en_a, bank_addr_a, bank_we_a});
        else n_pass++;
        @(negedge clk);
        ena = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({rvalid_a, rdata_a} !== {1'b1, 8'h5A})
            $display("FAIL read_return: got %b/%h expected 1/5a", rvalid_a, rdata_a);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({rvalid_a, rdata_a} !== {1'b0, 8'h00})
            $display("FAIL read_single: got %b/%h expected 0/00", rvalid_a, rdata_a);
        else n_pass++;
    endtask

    task automatic test_mid_read_reset();
        @(negedge clk);
        ena = 1'b1; wea = 1'b0; addra = 8'hC7;
        @(posedge clk); #1;
        n_total++;
        if (bank_en_a !== 4'b1000) $display("FAIL midrst_issue: got %b expected 1000", bank_en_a);
        else n_pass++;
        @(negedge clk);
        ena = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({rvalid_a, rdata_a} !== 9'd0) $display("FAIL midrst_rvalid: got %b/%h expected 0/00", rvalid_a, rdata_a);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; ena = 1'b1; enb = 1'b1; addra = 8'h00; addrb = 8'h3F;
        #1;
        n_total++;
        if ({rdy_a, rdy_b} !== 2'b10) $display("FAIL midrst_prio: rdy got %b expected 10", {rdy_a, rdy_b});
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({rvalid_a, bank_en_a} !== 5'b0_0001) $display("FAIL midrst_after: got %b", {rvalid_a, bank_en_a});
        else n_pass++;
        @(negedge clk);
        ena = 1'b0; enb = 1'b0;
    endtask

    task automatic test_param();
        p8_bank_rdata_b = 64'h0000_0000_0000_C300;
        @(negedge clk);
        p8_ena = 1'b1; p8_wea = 1'b1; p8_addra = 8'hE3; p8_data_a = 8'h77;
        p8_enb = 1'b1; p8_web = 1'b0; p8_addrb = 8'h23;
        #1;
        n_total++;
        if ({p8_rdy_a, p8_rdy_b} !== 2'b11) $display("FAIL p8_rdy: got %b expected 11", {p8_rdy_a, p8_rdy_b});
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({p8_bank_en_a, p8_bank_addr_a, p8_bank_en_b, p8_bank_addr_b} !== {8'h80, 5'h03, 8'h02, 5'h03})
            $display("FAIL p8_decode: got %h", {p8_bank_en_a, p8_bank_addr_a, p8_bank_en_b, p8_bank_addr_b});
        else n_pass++;
        @(negedge clk);
        p8_ena = 1'b0; p8_enb = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({p8_rvalid_b, p8_rdata_b, p8_rvalid_a} !== {1'b1, 8'hC3, 1'b0})
            $display("FAIL p8_read: got %h", {p8_rvalid_b, p8_rdata_b, p8_rvalid_a});
        else n_pass++;
    endtask

    task automatic test_random();
        int exp_rd_a [NCYC+3];
        int exp_rd_b [NCYC+3];
        bit m_prio, hold_a, hold_b, conflict, ea, eb;
        logic [NB-1:0] m_en_a, m_en_b;
        logic m_we_a, m_we_b;
        logic [WW-1:0] m_addr_a, m_addr_b;
        logic [DW-1:0] m_data_a, m_data_b, xa, xb;
        logic [15:0] m_cnt;
        for (int i = 0; i < NCYC + 3; i++) begin exp_rd_a[i] = -1; exp_rd_b[i] = -1; end
        @(negedge clk);
        rst = 1'b1; ena = 1'b0; enb = 1'b0;
        @(posedge clk);
        m_prio = 0; hold_a = 0; hold_b = 0; m_cnt = '0;
        m_en_a = '0; m_en_b = '0; m_we_a = 0; m_we_b = 0;
        m_addr_a = '0; m_addr_b = '0; m_data_a = '0; m_data_b = '0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            n_total++;
            if ({bank_en_a, bank_we_a, bank_addr_a, bank_data_a, bank_en_b, bank_we_b, bank_addr_b, bank_data_b}
                !== {m_en_a, m_we_a, m_addr_a, m_data_a, m_en_b, m_we_b, m_addr_b, m_data_b})
                $display("FAIL rand_bank_req c=%0d: got %h expected %h", c,
                    {bank_en_a, bank_we_a, bank_addr_a, bank_data_a, bank_en_b, bank_we_b, bank_addr_b, bank_data_b},
                    {m_en_a, m_we_a, m_addr_a, m_data_a, m_en_b, m_we_b, m_addr_b, m_data_b});
            else n_pass++;
            n_total++;
            if ({rvalid_a, rvalid_b} !== {exp_rd_a[c] >= 0, exp_rd_b[c] >= 0})
                $display("FAIL rand_rvalid c=%0d: got %b expected %b", c, {rvalid_a, rvalid_b},
                    {exp_rd_a[c] >= 0, exp_rd_b[c] >= 0});
            else n_pass++;
`ifdef BANK_CONFLICT_STATS_EN
            n_total++;
            if (conflict_cnt !== m_cnt) $display("FAIL rand_cnt c=%0d: got %0d expected %0d", c, conflict_cnt, m_cnt);
            else n_pass++;
`endif
            rst = ($urandom_range(0, 99) == 0);
            if (!hold_a) begin
                ena = ($urandom_range(0, 3) != 0); wea = 1'($urandom);
                addra = 8'($urandom); data_a = 8'($urandom);
            end
            if (!hold_b) begin
                enb = ($urandom_range(0, 3) != 0); web = 1'($urandom);
                addrb = 8'($urandom); data_b = 8'($urandom);
            end
            bank_rdata_a = $urandom;
            bank_rdata_b = $urandom;
            #1;
            conflict = ena && enb && (addra[7:6] == addrb[7:6]);
            ea = !conflict || !m_prio;
            eb = !conflict || m_prio;
            n_total++;
            if ({rdy_a, rdy_b} !== {ea, eb})
                $display("FAIL rand_rdy c=%0d: got %b expected %b", c, {rdy_a, rdy_b}, {ea, eb});
            else n_pass++;
            xa = (exp_rd_a[c] >= 0) ? 8'(bank_rdata_a >> (8 * exp_rd_a[c])) : 8'h00;
            xb = (exp_rd_b[c] >= 0) ? 8'(bank_rdata_b >> (8 * exp_rd_b[c])) : 8'h00;
            n_total++;
            if ({rdata_a, rdata_b} !== {xa, xb})
                $display("FAIL rand_rdata c=%0d: got %h expected %h", c, {rdata_a, rdata_b}, {xa, xb});
            else n_pass++;
`ifdef BANK_CONFLICT_STATS_EN
            n_total++;
            if ({stall_a, stall_b} !== {ena && !ea, enb && !eb})
                $display("FAIL rand_stall c=%0d: got %b expected %b", c, {stall_a, stall_b}, {ena && !ea, enb && !eb});
            else n_pass++;
`endif
            if (rst) begin
                m_prio = 0; m_cnt = '0; hold_a = 0; hold_b = 0;
                m_en_a = '0; m_en_b = '0; m_we_a = 0; m_we_b = 0;
                m_addr_a = '0; m_addr_b = '0; m_data_a = '0; m_data_b = '0;
                exp_rd_a[c+1] = -1; exp_rd_b[c+1] = -1;
            end else begin
                m_en_a = '0; m_en_b = '0;
                if (ena && ea) begin
                    m_en_a = 4'b0001 << addra[7:6];
                    m_we_a = wea; m_addr_a = addra[5:0]; m_data_a = data_a;
                    if (!wea) exp_rd_a[c+2] = int'(addra[7:6]);
                end
                if (enb && eb) begin
                    m_en_b = 4'b0001 << addrb[7:6];
                    m_we_b = web; m_addr_b = addrb[5:0]; m_data_b = data_b;
                    if (!web) exp_rd_b[c+2] = int'(addrb[7:6]);
                end
                if (conflict) begin
                    m_prio = !m_prio;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
                hold_a = ena && !ea;
                hold_b = enb && !eb;
            end
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b0; ena = 1'b0; enb = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
        addra = '0; addrb = '0; data_a = '0; data_b = '0;
        bank_rdata_a = '0; bank_rdata_b = '0;
        p8_ena = 1'b0; p8_enb = 1'b0; p8_wea = 1'b0; p8_web = 1'b0;
        p8_addra = '0; p8_addrb = '0; p8_data_a = '0; p8_data_b = '0;
        p8_bank_rdata_a = '0; p8_bank_rdata_b = '0;
        test_reset();
        test_disjoint();
        test_conflict();
        test_read_return();
        test_mid_read_reset();
        test_param();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
